// File: rtl/irq_pkg.sv
// irq_pkg: shared types and defaults for the interrupt arbiter.
//   irq_state_e : arbiter FSM states (IDLE, REQ, EXEC, HOLD)
//   N_SRC_DEF   : default number of interrupt sources
//   VEC_W_DEF   : default vector-number width
//   vec_num()   : maps a granted source index to its vector number
package irq_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int VEC_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HOLD = 2'd3
  } irq_state_e;

  // Vector 0 is the reset vector, so source i uses vector i+1.
  function automatic int vec_num(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder.
//   req_i   [N-1:0]     : request bits, bit 0 has highest priority
//   found_o             : at least one request bit set
//   idx_o   [IDX_W-1:0] : index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: fixed-priority interrupt arbiter between peripherals and CPU.
// Collects level requests, gates them with the global I-bit and the source
// mask, presents one registered vector to the CPU and returns a one-cycle
// executed pulse to the granted source on acknowledge.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   src_req  [N_SRC]   : level interrupt requests from peripherals
//   src_exec [N_SRC]   : one-hot executed pulse back to the granted peripheral
//   sreg_i             : global interrupt enable (SREG I-bit)
//   irq_valid          : interrupt pending toward the CPU
//   irq_vector [VEC_W] : granted index + 1, held outside REQ
//   cpu_ack            : CPU accepts the presented vector (ignored outside REQ)
//   addr/write/read/wdata/rdata : I/O bus for the mask register
//
// Build option: IRQ_MASK_REG_EN adds a bus-accessible source mask register at
// MASK_ADDR. Without it the mask is all-ones, bus inputs are ignored and
// rdata is 0.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int         N_SRC     = N_SRC_DEF,
  parameter int         VEC_W     = VEC_W_DEF,
  parameter logic [7:0] MASK_ADDR = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_req,
  output logic [N_SRC-1:0] src_exec,
  input  logic             sreg_i,
  output logic             irq_valid,
  output logic [VEC_W-1:0] irq_vector,
  input  logic             cpu_ack,
  input  logic [7:0]       addr,
  input  logic             write,
  input  logic             read,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  irq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [N_SRC-1:0] mask;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // ---------------------------------------------------------------------------
  // Source mask
  // ---------------------------------------------------------------------------
`ifdef IRQ_MASK_REG_EN
  logic [N_SRC-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (write && addr == MASK_ADDR) mask_d = wdata[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '1;
    else     mask_q <= mask_d;
  end

  assign mask = mask_q;

  // Bits above N_SRC read back as zero.
  always_comb begin
    rdata = '0;
    if (read && addr == MASK_ADDR) rdata[N_SRC-1:0] = mask_q;
  end
`else
  logic unused_bus;
  assign unused_bus = ^{addr, write, read, wdata};
  assign mask       = '1;
  assign rdata      = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (src_req & mask),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (sreg_i && win_found) begin
          idx_d   = win_idx;
          vec_d   = VEC_W'(vec_num(int'(win_idx)));
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack has priority over a simultaneous withdraw. A newly arriving
        // higher-priority source is not looked at here: no preemption.
        if (cpu_ack)
          state_d = EXEC;
        else if (!sreg_i || !src_req[idx_q] || !mask[idx_q])
          state_d = IDLE;
      end
      EXEC:    state_d = HOLD;
      // One dead cycle lets the peripheral's registered request fall.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  // Outputs decode registered state only, so reset kills any EXEC pulse on
  // the very next edge.
  assign irq_valid  = (state_q == REQ);
  assign irq_vector = vec_q;
  assign src_exec   = (state_q == EXEC) ? (N_SRC'(1) << idx_q) : '0;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_req;
  logic [7:0] src_exec;
  logic       sreg_i;
  logic       irq_valid;
  logic [5:0] irq_vector;
  logic       cpu_ack;
  logic [7:0] addr;
  logic       write;
  logic       read;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  irq_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .src_req    (src_req),
    .src_exec   (src_exec),
    .sreg_i     (sreg_i),
    .irq_valid  (irq_valid),
    .irq_vector (irq_vector),
    .cpu_ack    (cpu_ack),
    .addr       (addr),
    .write      (write),
    .read       (read),
    .wdata      (wdata),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  // Scoreboard: kind 0 = irq_valid rising with vector, kind 1 = exec pulse.
  typedef struct {
    logic       kind;
    logic [7:0] val;
  } ev_t;

  ev_t exp_q[$];

  task automatic push(input logic kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (irq_valid === 1'b1 && prev_v !== 1'b1) check_ev(1'b0, {2'b00, irq_vector});
    if (src_exec !== 8'h00 && !$isunknown(src_exec)) check_ev(1'b1, src_exec);
    prev_v = irq_valid;
  end

  task automatic check_ev(input logic kind, input logic [7:0] val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: kind %0d value %h, none expected at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.val !== val) begin
        n_err++;
        $display("FAIL sb_event: got kind %0d value %h, expected kind %0d value %h at %0t",
                 kind, val, e.kind, e.val, $time);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; src_req = '0; sreg_i = 1'b0; cpu_ack = 1'b0;
    addr = '0; write = 1'b0; read = 1'b0; wdata = '0;
    tick(2);
    rst = 1'b0;
    tick();
    chk("reset_valid",  {7'd0, irq_valid}, 8'h00);
    chk("reset_vector", {2'd0, irq_vector}, 8'h00);
    chk("reset_exec",   src_exec, 8'h00);
    chk("reset_rdata",  rdata, 8'h00);

    // Single source, ack, re-grant no earlier than k+4.
    src_req = 8'h08; sreg_i = 1'b1;
    push(1'b0, 8'd4);
    tick();
    chk("single_valid",  {7'd0, irq_valid}, 8'h01);
    chk("single_vector", {2'd0, irq_vector}, 8'd4);
    cpu_ack = 1'b1;                       // cycle k
    push(1'b1, 8'h08);
    tick();
    cpu_ack = 1'b0;
    chk("single_exec",       src_exec, 8'h08);
    chk("single_exec_valid", {7'd0, irq_valid}, 8'h00);
    push(1'b0, 8'd4);
    tick();
    chk("hold_no_exec",  src_exec, 8'h00);
    chk("hold_valid_k2", {7'd0, irq_valid}, 8'h00);
    tick();
    chk("idle_valid_k3", {7'd0, irq_valid}, 8'h00);
    tick();
    chk("regrant_k4",    {7'd0, irq_valid}, 8'h01);

    // Ack and withdraw together: ack wins.
    cpu_ack = 1'b1; src_req = 8'h00;
    push(1'b1, 8'h08);
    tick();
    cpu_ack = 1'b0;
    chk("ackwin_exec", src_exec, 8'h08);
    tick();
    chk("ackwin_pulse_one_cycle", src_exec, 8'h00);
    tick(2);

    // Simultaneous requests, then the lower-priority one.
    src_req = 8'h24;
    push(1'b0, 8'd3);
    tick();
    chk("simul_vector", {2'd0, irq_vector}, 8'd3);
    cpu_ack = 1'b1;
    push(1'b1, 8'h04);
    tick();
    cpu_ack = 1'b0; src_req = 8'h20;
    push(1'b0, 8'd6);
    tick(3);
    chk("second_vector", {2'd0, irq_vector}, 8'd6);

    // No preemption, then withdraw via I-bit.
    src_req = 8'h22;
    tick(2);
    chk("nopreempt_valid",  {7'd0, irq_valid}, 8'h01);
    chk("nopreempt_vector", {2'd0, irq_vector}, 8'd6);
    sreg_i = 1'b0;
    tick();
    chk("withdraw_valid", {7'd0, irq_valid}, 8'h00);
    chk("withdraw_exec",  src_exec, 8'h00);
    chk("withdraw_vector_held", {2'd0, irq_vector}, 8'd6);
    tick();
    chk("withdraw_exec2", src_exec, 8'h00);
    src_req = 8'h00; sreg_i = 1'b1;
    tick();

    // Mask register.
    addr = 8'hF0; wdata = 8'hFE; write = 1'b1;
    tick();
    write = 1'b0; read = 1'b1;
    #1;
`ifdef IRQ_MASK_REG_EN
    chk("mask_readback", rdata, 8'hFE);
    read = 1'b0;
    src_req = 8'h01;
    tick(3);
    chk("masked_no_valid", {7'd0, irq_valid}, 8'h00);
    src_req = 8'h00;
    tick();
`else
    chk("mask_readback_off", rdata, 8'h00);
    read = 1'b0;
    src_req = 8'h01;
    push(1'b0, 8'd1);
    tick();
    chk("unmasked_valid", {7'd0, irq_valid}, 8'h01);
    cpu_ack = 1'b1; src_req = 8'h00;
    push(1'b1, 8'h01);
    tick();
    cpu_ack = 1'b0;
    tick(2);
`endif

    // Reset in REQ.
    src_req = 8'h10;
    push(1'b0, 8'd5);
    tick();
    chk("pre_rst_vector", {2'd0, irq_vector}, 8'd5);
    rst = 1'b1;
    tick();
    chk("rstreq_valid",  {7'd0, irq_valid}, 8'h00);
    chk("rstreq_vector", {2'd0, irq_vector}, 8'h00);
    chk("rstreq_exec",   src_exec, 8'h00);
    rst = 1'b0;
    push(1'b0, 8'd5);
    tick();
    chk("post_rst_valid", {7'd0, irq_valid}, 8'h01);

    // Reset in EXEC.
    cpu_ack = 1'b1;
    push(1'b1, 8'h10);
    tick();
    cpu_ack = 1'b0; rst = 1'b1;
    tick();
    chk("rstexec_exec",   src_exec, 8'h00);
    chk("rstexec_valid",  {7'd0, irq_valid}, 8'h00);
    chk("rstexec_vector", {2'd0, irq_vector}, 8'h00);
    read = 1'b1; addr = 8'hF0;
    #1;
`ifdef IRQ_MASK_REG_EN
    chk("mask_after_rst", rdata, 8'hFF);
`else
    chk("rdata_after_rst_off", rdata, 8'h00);
`endif
    read = 1'b0;
    rst = 1'b0; src_req = 8'h01;
    push(1'b0, 8'd1);
    tick();
    chk("src0_after_rst", {2'd0, irq_vector}, 8'd1);
    sreg_i = 1'b0; src_req = 8'h00;
    tick(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Fixed-priority interrupt arbiter between the peripheral blocks (timer/counters and others) and the CPU core. It collects each peripheral's level `interrupt_request` and gates them with the global I-bit and an optional per-source mask. It presents one registered vector request to the CPU and, on CPU acknowledge, returns a one-cycle `interrupt_executed` pulse to the granted peripheral so that peripheral can clear its flag and drop its request.

## Interface
- `N_SRC`, 8: number of interrupt sources; source 0 has the highest priority.
- `VEC_W`, 6: width of the vector number output.
- `MASK_ADDR`, 8'hF0: I/O address of the mask register (used only with `IRQ_MASK_REG_EN`).

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high, one clock.
- `src_req`  in  N_SRC  level `interrupt_request` from each peripheral.
- `src_exec`  out  N_SRC  one-hot `interrupt_executed` pulse back to peripherals.
- `sreg_i`  in  1  global interrupt enable (SREG I-bit).
- `irq_valid`  out  1  interrupt pending toward the CPU.
- `irq_vector`  out  VEC_W  vector number, equal to granted index + 1 (0 is reserved for reset).
- `cpu_ack`  in  1  CPU accepts the presented vector.
- `addr`  in  8; `write`  in  1; `read`  in  1; `wdata`  in  8; `rdata`  out  8: I/O bus for the mask register.

## Operation
- Eligible set = `src_req & mask`, where mask is all-ones without the macro. The winner is the lowest eligible index.
- FSM states:
  - IDLE: if `sreg_i` and eligible is non-zero, latch the winner index and go to REQ.
  - REQ: `irq_valid`=1 and `irq_vector`=latched index+1; both are stable throughout REQ.
    - `cpu_ack` → EXEC.
    - Else if `sreg_i`=0, or the latched source's `src_req` drops, or its mask bit clears → IDLE (request withdrawn, no exec pulse).
    - A higher-priority source arriving in REQ does not preempt; it is served on the next arbitration.
  - EXEC: `src_exec[idx]`=1 for exactly this cycle; `irq_valid`=0. → HOLD.
  - HOLD: one cycle with no arbitration, so the peripheral's registered request can deassert. → IDLE.
- `cpu_ack` outside REQ is ignored.
- `irq_vector` holds its last value outside REQ.
- Reset values:
  - State IDLE.
  - `irq_valid`=0, `src_exec`=0, `irq_vector`=0.
  - Mask=all-ones.
  - `rdata`=0 when not driven.

## Timing
- Request sampled in IDLE at cycle n → `irq_valid` high at n+1.
- `cpu_ack` high at cycle k while in REQ → `src_exec` pulse at k+1, HOLD at k+2, IDLE at k+3. The earliest next `irq_valid` is k+4.
- Withdraw condition seen at cycle k in REQ → `irq_valid` low at k+1.
- `cpu_ack` and a withdraw condition in the same cycle: ack wins (EXEC).
- Reset asserted in any state: IDLE on the next edge, and no pending `src_exec` pulse is emitted.
- Bus write to the mask register takes effect on the next edge. Eligibility uses the registered mask.

## Configuration
- `IRQ_MASK_REG_EN`:
  - Defined: 8-bit mask register at `MASK_ADDR`; bits above `N_SRC` read 0. Writable via `write`; readable via `read` (combinational `rdata`).
  - Undefined: mask is constant all-ones. Bus inputs are ignored and `rdata`=0. Ports remain present.

## Structure
- Package `irq_pkg`: FSM state enum (IDLE, REQ, EXEC, HOLD), default `N_SRC`, `VEC_W`, and a vector-number helper function.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder producing a found flag and an index. The arbiter instantiates it once.

## Test plan
- **Single source:** `src_req[3]`=1, `sreg_i`=1 → `irq_valid` next cycle with `irq_vector`=4. `cpu_ack` → `src_exec`=8'h08 for one cycle, with no re-grant until k+4.
- **Simultaneous requests:** `src_req`=8'h24 → vector 3 served first. After exec, and with `src_req[2]` dropped, vector 6 is served.
- **No preemption and withdraw:** source 5 in REQ, then `src_req[1]` rises → vector stays 6. Then `sreg_i`=0 → `irq_valid` low next cycle and `src_exec` stays 0.
- **Ack wins over withdraw:** `cpu_ack` and `src_req` drop in the same cycle → EXEC, with `src_exec` pulsed.
- **Mask register (macro on):** write 8'hFE to `MASK_ADDR`, then `src_req`=8'h01 → no `irq_valid`; readback returns 8'hFE. With the macro off, the same write leaves source 0 served.
- **Reset mid-operation:** `rst` asserted in REQ and in EXEC → all outputs 0 next cycle and mask returns to 8'hFF.
